packet_receiver: RTL and testbench

Input stage of the router port, directly upstream of the packet sender. Accepts a byte stream from the link, parses SRC/DST/SIZE/DATA/CRC framing, and checks the XOR checksum. Good packets are committed into a multi-slot packet buffer. The downstream sender reads committed packets by byte offset through `rempty` / `raddr_in` / `rdata` / `rinc`.

---
 rtl/packet_receiver.sv | 95 +++++++++
 tb/tb_packet_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_receiver.sv
// packet_receiver: parses SRC/DST/SIZE/DATA/CRC link packets, checks the XOR
// checksum and commits good packets into a multi-slot buffer read by byte offset.
//   clk, rst (async, active-low)
//   packet_in/packet_in_valid : link byte stream, one packet per valid burst
//   raddr_in/rdata            : combinational byte read of the head slot
//   rinc                      : release head slot
//   rempty/wfull              : buffer status from registered pointers
//   crc_err/frame_err/drop    : one-cycle discard pulses
module packet_receiver #(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int PTR_SZ    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [UWIDTH-1:0]    packet_in,
    input  logic                 packet_in_valid,
    input  logic [PTR_IN_SZ-1:0] raddr_in,
    input  logic                 rinc,
    output logic [UWIDTH-1:0]    rdata,
    output logic                 rempty,
    output logic                 wfull,
    output logic                 crc_err,
    output logic                 frame_err,
    output logic                 drop
);
    typedef enum logic [2:0] {IDLE, HDR, SIZE, DATA, CRC, FLUSH} state_t;

    state_t               state_q;
    logic [PTR_SZ:0]      wptr_q, rptr_q;
    logic [PTR_IN_SZ-1:0] woff_q;
    logic [2:0]           dcnt_q;
    logic [UWIDTH-1:0]    xor_q;
    logic                 commit_q;
    logic [UWIDTH-1:0]    mem [2**PTR_SZ][2**PTR_IN_SZ];

    logic                 in_pkt, start, wr_en, commit, gap;
    logic [PTR_IN_SZ-1:0] waddr;

    assign rempty = wptr_q == rptr_q;
    assign wfull  = (wptr_q[PTR_SZ] != rptr_q[PTR_SZ]) && (wptr_q[PTR_SZ-1:0] == rptr_q[PTR_SZ-1:0]);
    assign in_pkt = state_q inside {HDR, SIZE, DATA, CRC};
    // A byte right after a commit is a framing error, so it never opens a packet.
    assign start  = state_q == IDLE && packet_in_valid && !commit_q && !wfull;
    assign wr_en  = start || (in_pkt && packet_in_valid);
    assign waddr  = state_q == IDLE ? '0 : woff_q;
    assign commit = state_q == CRC && packet_in_valid && packet_in == xor_q;
    assign gap    = in_pkt && !packet_in_valid;
    assign rdata  = mem[rptr_q[PTR_SZ-1:0]][raddr_in];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q[PTR_SZ-1:0]][waddr] <= packet_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            woff_q    <= '0;
            dcnt_q    <= '0;
            xor_q     <= '0;
            commit_q  <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            drop      <= 1'b0;
        end else begin
            commit_q  <= commit;
            crc_err   <= state_q == CRC && packet_in_valid && !commit;
            frame_err <= gap || (state_q == IDLE && packet_in_valid && commit_q);
            drop      <= state_q == IDLE && packet_in_valid && !commit_q && wfull;
            if (commit) wptr_q <= wptr_q + (PTR_SZ+1)'(1);
            if (rinc && !rempty) rptr_q <= rptr_q + (PTR_SZ+1)'(1);
            if (wr_en) begin
                woff_q <= waddr + PTR_IN_SZ'(1);
                xor_q  <= start ? packet_in : xor_q ^ packet_in;
            end
            case (state_q)
                IDLE:    state_q <= !packet_in_valid ? IDLE : start ? HDR : FLUSH;
                HDR:     state_q <= packet_in_valid ? SIZE : IDLE;
                SIZE: begin
                    state_q <= packet_in_valid ? DATA : IDLE;
                    dcnt_q  <= packet_in[2:0];
                end
                DATA: begin
                    state_q <= !packet_in_valid ? IDLE : dcnt_q == 3'd0 ? CRC : DATA;
                    dcnt_q  <= dcnt_q - 3'd1;
                end
                CRC:     state_q <= !packet_in_valid || commit ? IDLE : FLUSH;
                FLUSH:   state_q <= packet_in_valid ? FLUSH : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: scoreboard bench for packet_receiver with a queue-based reference model.
module tb_packet_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] packet_in = '0;
    logic       packet_in_valid = 1'b0;
    logic [3:0] raddr_in = '0;
    logic       rinc = 1'b0;
    logic [7:0] rdata;
    logic       rempty, wfull, crc_err, frame_err, drop;

    always #5 clk = ~clk;

    packet_receiver dut (
        .clk(clk), .rst(rst), .packet_in(packet_in), .packet_in_valid(packet_in_valid),
        .raddr_in(raddr_in), .rinc(rinc), .rdata(rdata), .rempty(rempty), .wfull(wfull),
        .crc_err(crc_err), .frame_err(frame_err), .drop(drop)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] sb_bytes[$];
    int         sb_len[$];
    int         evq[$];
    logic [7:0] pkt[12];
    int         plen;
    int         occ;
    logic       pkt_commit = 1'b0;
    logic       rd_en = 1'b0;
    logic       rd_busy = 1'b0;
    logic       rempty_at_last, rempty_after;

    always @(posedge clk or negedge rst)
        if (!rst) occ <= 0;
        else occ <= occ + (pkt_commit ? 1 : 0) - ((rinc && occ != 0) ? 1 : 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input logic [7:0] z, input bit badcrc);
        logic [7:0] x;
        int n;
        n = z[2:0] + 1;
        plen = 4 + n;
        pkt[0] = 8'($urandom);
        pkt[1] = 8'($urandom);
        pkt[2] = z;
        x = pkt[0] ^ pkt[1] ^ z;
        for (int i = 0; i < n; i++) begin
            pkt[3+i] = 8'($urandom);
            x ^= pkt[3+i];
        end
        pkt[3+n] = badcrc ? x ^ 8'($urandom_range(1, 255)) : x;
    endtask

    task automatic send(input int cut, input bit co_rinc, input bit nogap);
        logic [7:0] x;
        bit good;
        int n;
        @(negedge clk);
        x = '0;
        for (int i = 0; i < plen - 1; i++) x ^= pkt[i];
        good = 0;
        if (occ == 4) evq.push_back(4);
        else if (cut < plen) evq.push_back(2);
        else if (pkt[plen-1] != x) evq.push_back(1);
        else begin
            good = 1;
            for (int i = 0; i < plen; i++) sb_bytes.push_back(pkt[i]);
            sb_len.push_back(plen);
        end
        for (int i = 0; i < cut; i++) begin
            if (i > 0) @(negedge clk);
            packet_in = pkt[i];
            packet_in_valid = 1'b1;
            if (i == plen - 1) begin
                rempty_at_last = rempty;
                pkt_commit = good;
                if (co_rinc) begin
                    rinc = 1'b1;
                    n = sb_len.pop_front();
                    repeat (n) void'(sb_bytes.pop_front());
                end
            end
        end
        @(negedge clk);
        pkt_commit = 1'b0;
        if (co_rinc) rinc = 1'b0;
        rempty_after = rempty;
        if (!nogap) begin
            packet_in_valid = 1'b0;
            packet_in = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic read_head();
        int n;
        if (sb_len.size() == 0) begin
            total++;
            bad++;
            $display("FAIL read_head: rempty=%0b with no packet expected", rempty);
            @(negedge clk);
        end else begin
            n = sb_len.pop_front();
            for (int k = 0; k < n; k++) begin
                raddr_in = 4'(k);
                #2;
                chk($sformatf("rdata[%0d]", k), rdata, sb_bytes.pop_front());
                if (k == n - 1) rinc = 1'b1;
                @(negedge clk);
            end
            rinc = 1'b0;
        end
    endtask

    task automatic drain();
        rd_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sb_len.size() == 0 && !rd_busy && rempty) break;
        end
        rd_en = 1'b0;
        chk("drain_sb", sb_len.size(), 0);
        chk("drain_rempty", rempty, 1);
    endtask

    initial forever begin
        @(negedge clk);
        if (rd_en && rst && !rempty && $urandom_range(0, 2) != 0) begin
            rd_busy = 1'b1;
            read_head();
            rd_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (crc_err || frame_err || drop) begin
            if (evq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pulse: unexpected code %0d (drop,frame,crc)", {drop, frame_err, crc_err});
            end else chk("pulse", {drop, frame_err, crc_err}, evq.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    logic [7:0] t1[6] = '{8'h05, 8'h02, 8'h01, 8'hAA, 8'hBB, 8'h17};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rempty", rempty, 1);
        chk("rst_wfull", wfull, 0);
        chk("rst_pulses", {drop, frame_err, crc_err}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rempty_rel", rempty, 1);

        for (int i = 0; i < 6; i++) pkt[i] = t1[i];
        plen = 6;
        send(6, 0, 0);
        chk("t1_rempty_at_crc", rempty_at_last, 1);
        chk("t1_rempty_after", rempty_after, 0);
        @(negedge clk);
        read_head();
        chk("t1_rempty_rel", rempty, 1);

        pkt[5] = 8'h18;
        send(6, 0, 0);
        repeat (3) @(negedge clk);
        chk("t2_crc_seen", evq.size(), 0);
        chk("t2_rempty", rempty, 1);

        build(8'h03, 0);
        send(5, 0, 0);
        repeat (3) @(negedge clk);
        chk("t3_frame_seen", evq.size(), 0);
        chk("t3_rempty", rempty, 1);
        build(8'($urandom), 0);
        send(plen, 0, 0);
        drain();

        build(8'($urandom), 0);
        send(plen, 0, 1);
        evq.push_back(2);
        packet_in = 8'($urandom);
        repeat (2) begin
            @(negedge clk);
            packet_in = 8'($urandom);
        end
        @(negedge clk);
        packet_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("postcommit_frame_seen", evq.size(), 0);
        drain();

        repeat (4) begin
            build(8'($urandom), 0);
            send(plen, 0, 0);
        end
        chk("t4_wfull", wfull, 1);
        build(8'($urandom), 0);
        send(plen, 0, 0);
        repeat (2) @(negedge clk);
        chk("t4_drop_seen", evq.size(), 0);
        chk("t4_wfull_after_drop", wfull, 1);
        read_head();
        chk("t4_wfull_rel", wfull, 0);
        build(8'($urandom), 0);
        send(plen, 0, 0);
        chk("t4_wfull_refill", wfull, 1);
        drain();

        repeat (2) begin
            build(8'($urandom), 0);
            send(plen, 0, 0);
        end
        build(8'($urandom), 0);
        send(plen, 1, 0);
        chk("t5_wfull", wfull, 0);
        @(negedge clk);
        read_head();
        chk("t5_rempty_mid", rempty, 0);
        read_head();
        chk("t5_rempty_end", rempty, 1);

        build(8'($urandom), 0);
        send(plen, 0, 0);
        build(8'h07, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            packet_in = pkt[i];
            packet_in_valid = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        packet_in_valid = 1'b0;
        sb_len.delete();
        sb_bytes.delete();
        repeat (2) @(negedge clk);
        chk("t6_rempty_in_rst", rempty, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rempty", rempty, 1);
        chk("t6_pulses", {drop, frame_err, crc_err}, 0);
        build(8'($urandom), 0);
        send(plen, 0, 0);
        chk("t6_rempty_new", rempty_after, 0);
        drain();

        rd_en = 1'b1;
        for (int p = 0; p < 60; p++) begin
            build(8'($urandom), $urandom_range(0, 5) == 0);
            send(($urandom_range(0, 5) == 0) ? int'($urandom_range(1, plen - 1)) : plen, 0, 0);
        end
        drain();
        repeat (5) @(negedge clk);
        chk("final_evq", evq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
